// File: rtl/sdm_dwa.sv
// Data-weighted-averaging element selector: turns a modulator code into a
// thermometer run of unit-element enables that starts at a rotating pointer.
module sdm_dwa #(
  parameter int NB  = 4,
  parameter int NEL = 15,
  parameter int PW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NB-1:0]  din,
  input  logic           din_vld,
  input  logic           mode,
  output logic [NEL-1:0] el_out,
  output logic           el_vld,
  output logic [PW-1:0]  ptr,
  output logic           ovf
);

  localparam logic [NB-1:0] NEL_N = NB'(NEL);
  localparam logic [PW:0]   NEL_P = (PW+1)'(NEL);

  logic [NEL-1:0]   r_el_out;
  logic             r_el_vld;
  logic [PW-1:0]    r_ptr;
  logic             r_ovf;

  logic             w_ovf;
  logic [NB-1:0]    w_n;
  logic [PW-1:0]    w_start;
  logic [NEL-1:0]   w_therm;
  logic [2*NEL-1:0] w_wide;
  logic [NEL-1:0]   w_el;
  logic [PW:0]      w_sum;
  logic [PW:0]      w_next;

  // Comparison done at 32 bits so a full-range din never reads as a constant test.
  assign w_ovf   = (int'(din) > NEL);
  assign w_n     = w_ovf ? NEL_N : din;
  assign w_start = mode ? r_ptr : '0;

  always_comb begin
    w_therm = '0;
    for (int k = 0; k < NEL; k++) begin
      w_therm[k] = (k < int'(w_n));
    end
  end

  // Rotate inside a double-width word and fold the upper half back onto bit 0.
  assign w_wide = {{NEL{1'b0}}, w_therm} << w_start;
  assign w_el   = w_wide[NEL-1:0] | w_wide[2*NEL-1:NEL];

  assign w_sum  = {1'b0, w_start} + (PW+1)'(w_n);
  assign w_next = (w_sum >= NEL_P) ? (w_sum - NEL_P) : w_sum;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_el_out <= '0;
      r_el_vld <= 1'b0;
      r_ptr    <= '0;
      r_ovf    <= 1'b0;
    end else if (din_vld) begin
      r_el_out <= w_el;
      r_el_vld <= 1'b1;
      r_ptr    <= mode ? w_next[PW-1:0] : '0;
      r_ovf    <= w_ovf;
    end else begin
      r_el_vld <= 1'b0;
      r_ovf    <= 1'b0;
    end
  end

  assign el_out = r_el_out;
  assign el_vld = r_el_vld;
  assign ptr    = r_ptr;
  assign ovf    = r_ovf;

endmodule
